// File: rtl/uart_byte_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shift register.
// Bytes arrive on a strobe interface and leave LSB-first on a registered, idle-high line.
module uart_byte_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tx_new_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o,
  output logic       tx_o,
  output logic       idle_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic push;
  logic pop;
  logic fifo_empty;
  logic baud_last;

  // Handshake: tx_new_i is a one-cycle request; it is taken on the rising edge
  // only when tx_busy_o (FIFO full, judged before that edge's pop) is low, else dropped.
  assign tx_busy_o  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign push       = tx_new_i && !tx_busy_o;
  assign baud_last  = (baud_q == BAUD_MAX);

  assign tx_o   = tx_q;
  assign idle_o = (state_q == ST_IDLE) && fifo_empty;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: only entries covered by count_q are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames have no gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Line level follows the state being entered, so tx_q changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Directed bench for uart_byte_transmitter: strobes push expected bytes into exp_q,
// a line monitor rebuilds each 40-cycle frame and compares it against the queue head.
`timescale 1ns/1ps
module tb_uart_byte_transmitter;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       tx_new  = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy;
  logic       tx_o;
  logic       idle;

  uart_byte_transmitter #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .tx_new_i (tx_new),
    .tx_data_i(tx_data),
    .tx_busy_o(tx_busy),
    .tx_o     (tx_o),
    .idle_o   (idle)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks   = 0;
  int n_pass     = 0;
  int n_fail     = 0;
  int mon_frames = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] frame_vec(input logic [7:0] b);
    logic [9:0]  bits;
    logic [39:0] v;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 40; k++) v[k] = bits[k / CPB];
    return v;
  endfunction

  // Line monitor: frame starts on the first low sample, 40 samples per frame.
  int          mon_cyc    = 0;
  bit          mon_active = 1'b0;
  logic [39:0] frame_v    = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      mon_cyc    = 0;
    end else begin
      if (!mon_active && tx_o === 1'b0) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
      end
      if (mon_active) begin
        frame_v[mon_cyc] = tx_o;
        if (mon_cyc == 10 * CPB - 1) begin
          mon_active = 1'b0;
          mon_frames++;
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("frame_bits", frame_v, frame_vec(exp_q.pop_front()));
        end else begin
          mon_cyc++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b, input logic exp_busy);
    check($sformatf("busy_before_%02h", b), tx_busy, exp_busy);
    tx_new  = 1'b1;
    tx_data = b;
    if (!exp_busy) exp_q.push_back(b);
    @(negedge clk);
    tx_new = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, idle, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          bad;
    int          f0;
    logic [79:0] line_v;
    logic [79:0] line_exp;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", tx_o, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_idle", idle, 1);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({tx_o, tx_busy, idle} !== 3'b101) bad++;
    end
    check("quiet_after_reset", bad, 0);

    // Single byte 0xA5
    send(8'hA5, 1'b0);
    check("single_before_fall_tx", tx_o, 1);
    check("single_not_idle", idle, 0);
    @(negedge clk);
    check("single_fall", tx_o, 0);
    repeat (39) @(negedge clk);
    check("single_last_stop_cycle", {tx_o, idle}, 2'b10);
    @(negedge clk);
    check("single_idle_after_40", idle, 1);
    check("single_drained", exp_q.size(), 0);

    // Back-to-back 0x00, 0xFF
    repeat (3) @(negedge clk);
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    for (int i = 0; i < 80; i++) begin
      line_v[i] = tx_o;
      @(negedge clk);
    end
    line_exp = {{36{1'b1}}, {4{1'b0}}, {4{1'b1}}, {36{1'b0}}};
    check("b2b_line", line_v, line_exp);
    check("b2b_idle_after", idle, 1);
    check("b2b_drained", exp_q.size(), 0);

    // Full / drop: 0x06 arrives with the FIFO full
    repeat (3) @(negedge clk);
    f0 = mon_frames;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    send(8'h05, 1'b0);
    send(8'h06, 1'b1);
    check("full_busy_held", tx_busy, 1);
    wait_idle("full_idle", 6 * 10 * CPB);
    check("full_frame_count", mon_frames - f0, 5);
    check("full_drained", exp_q.size(), 0);

    // Write while full on the STOP-end pop edge
    repeat (3) @(negedge clk);
    f0 = mon_frames;
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    send(8'h14, 1'b0);
    send(8'h15, 1'b0);
    repeat (36) @(negedge clk);
    send(8'h77, 1'b1);
    check("pop_edge_busy_fall", tx_busy, 0);
    send(8'h88, 1'b0);
    wait_idle("pop_edge_idle", 7 * 10 * CPB);
    check("pop_edge_frame_count", mon_frames - f0, 6);
    check("pop_edge_drained", exp_q.size(), 0);

    // Reset mid-frame during DATA bit 3 with two bytes buffered
    repeat (3) @(negedge clk);
    f0 = mon_frames;
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b0);
    repeat (16) @(negedge clk);
    check("midframe_bit3_low", tx_o, 0);
    check("midframe_busy_low", tx_busy, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx_o, 1);
    check("async_rst_idle", idle, 1);
    check("async_rst_busy", tx_busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ({tx_o, idle} !== 2'b11) bad++;
    end
    check("post_rst_quiet", bad, 0);
    check("post_rst_no_frames", mon_frames - f0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_transmitter.md
# uart_byte_transmitter

Byte-to-serial UART transmitter: the line-side end of the chip's byte transmit handshake (`tx_new`/`tx_data`/`tx_busy`) that carries nonce results back to the host. It buffers bytes in a small FIFO and shifts each one out as an 8N1 frame (start, 8 data LSB-first, stop) at a fixed baud rate derived from the system clock. It sits between the chip's serial interface logic and the board's UART TX pin.

## Interface

Parameters:
- `CLKS_PER_BIT`, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 4, byte buffer entries; power of two, 2..16.

Ports:
- `clk_i`  input  1  system clock; all state changes on the rising edge.
- `rst_n_i`  input  1  asynchronous, active-low reset.
- `tx_new_i`  input  1  single-cycle strobe: `tx_data_i` is valid and requests enqueue.
- `tx_data_i`  input  8  byte to transmit.
- `tx_busy_o`  output  1  high when the FIFO is full; a strobe while high is dropped.
- `tx_o`  output  1  serial line, registered, idle high.
- `idle_o`  output  1  high when the FIFO is empty and no frame is in progress.

## Operation

- Reset (asynchronous assert, synchronous release): `tx_o`=1, `tx_busy_o`=0, `idle_o`=1, FIFO empty, FSM in IDLE, bit and baud counters 0. Reset mid-frame aborts the frame; `tx_o` goes high immediately; buffered bytes are discarded.
- Enqueue: on an edge with `tx_new_i`=1 and `tx_busy_o`=0, `tx_data_i` is written at the FIFO tail. A strobe with `tx_busy_o`=1 is ignored, with no state change.
- `tx_busy_o` is combinational from the FIFO count (count == `FIFO_DEPTH`). It is based on the count before the current edge's pop. A write on the same edge that a full FIFO pops is therefore dropped.
- FSM states:
  - IDLE: `tx_o`=1. On an edge where the FIFO is non-empty, pop the head into the shift register, set `tx_o`=0 and go to START.
  - START: `tx_o`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx_o`=shift[0] for `CLKS_PER_BIT` cycles per bit, then shift right. After bit index 7 completes, go to STOP.
  - STOP: `tx_o`=1 for `CLKS_PER_BIT` cycles. At the final cycle's edge:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle cycle);
    - otherwise go to IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary. It is held at 0 in IDLE.
- FIFO pointers: `$clog2(FIFO_DEPTH)` bits, wrapping modulo depth. Count is `$clog2(FIFO_DEPTH)`+1 bits. Simultaneous push and pop leaves the count unchanged.
- `idle_o` = (state == IDLE) and (count == 0).
- The FSM pops only at the IDLE-start and STOP-end edges described above. A push in the same cycle as an IDLE pop of an empty FIFO cannot happen: the pop requires the count to be non-zero before the edge.

## Timing

- Latency: a byte accepted at edge E0 into an empty FIFO with the FSM in IDLE is popped at edge E1. `tx_o` falls after E1.
- Frame length is exactly 10 × `CLKS_PER_BIT` cycles. Bit k (start = bit 0) spans cycles [E1 + k·`CLKS_PER_BIT`, E1 + (k+1)·`CLKS_PER_BIT`).
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle. There is zero idle gap.
- `tx_busy_o` deasserts on the cycle after the pop edge that makes room.
- `idle_o` rises on the cycle after the last stop-bit cycle when the FIFO is empty.

## Test plan

All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.

- **Reset values:** hold `rst_n_i`=0 → `tx_o`=1, `tx_busy_o`=0, `idle_o`=1. After release, with no strobes for 100 cycles, the outputs are unchanged.
- **Single byte:** one `tx_new_i` strobe with 0xA5. Required response:
  - `tx_o` falls 1 cycle after acceptance;
  - the line sequence is 0,1,0,1,0,0,1,0,1,1, each bit held exactly 4 cycles;
  - `idle_o` is high 40 cycles after the fall.
- **Back-to-back:** strobe 0x00 then 0xFF on consecutive cycles → two frames separated by no idle cycle. The line is low for 36 consecutive cycles (start + 8 zeros), then high for 4 (stop), low for 4 (start), high for 36 (8 ones + stop).
- **Full / drop:** strobe 6 bytes 0x01..0x06 on consecutive cycles.
  - 0x01 is popped at edge E1, so 0x02..0x05 fill the FIFO and `tx_busy_o` rises.
  - 0x06 is dropped.
  - Exactly 5 frames appear, carrying 0x01..0x05 in order.
- **Write while full at a pop edge:** fill the FIFO, then strobe on the STOP-end pop edge. The byte is dropped. `tx_busy_o` falls the next cycle, and a strobe then is accepted and sent last.
- **Reset mid-frame:** assert `rst_n_i` during DATA bit 3 with 2 bytes buffered.
  - `tx_o` goes high asynchronously.
  - After release, `tx_o` stays high and `idle_o`=1; no buffered frame is sent.
